urna_module: RTL and testbench
==============================

Name: urna_module

Overview:
- Synchronous four-candidate electronic ballot box ("urna").
- Accepts a 4-digit candidate code, one BCD digit at a time, through a Valid strobe.
- On the 4th digit, increments the matching candidate counter, or the null-vote counter if the code is unknown.
- Next arms a new ballot. Finish closes the election and freezes all totals; the counters are the block's result outputs.

Parameters:
- CNT_W, 8, width of each vote counter.
- CODE_C1, 16'h3494, BCD code of candidate 1.
- CODE_C2, 16'h3485, BCD code of candidate 2.
- CODE_C3, 16'h3472, BCD code of candidate 3.
- CODE_C4, 16'h3504, BCD code of candidate 4.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Digit  in  4  BCD digit being keyed.
- Valid  in  1  digit strobe; digit is accepted on its falling edge.
- Next  in  1  start new ballot (level, sampled each cycle).
- Finish  in  1  close election.
- C1..C4  out  CNT_W  vote totals for candidates 1..4.
- Nulo  out  CNT_W  null-vote total.
- StatusValido  out  1  last completed ballot was valid.
- StatusNulo  out  1  last completed ballot was null.

Behaviour:
- Reset (Reset_n=0, async): all counters 0, StatusValido=0, StatusNulo=0, digit buffer cleared, state=D0, registered Valid (valid_q)=0.
- Digit acceptance: valid_q <= Valid every cycle. A digit is accepted in the cycle where Valid=0 and valid_q=1; Digit is sampled in that same cycle. Digit may change while Valid is high.
- Any value 0..15 is accepted; values >9 simply make the code match no candidate.
- States: D0, D1, D2, D3 (n digits held), DONE, CLOSED.
  - Dn --accept--> Dn+1; the digit is shifted into a 16-bit buffer, MSD first.
  - D3 --accept--> DONE. In the same edge the full code is compared:
    - match CODE_Ck: Ck+1, StatusValido=1, StatusNulo=0.
    - otherwise: Nulo+1, StatusNulo=1, StatusValido=0.
  - DONE: further digit accepts are ignored until Next.
- Next=1 in any state except CLOSED: buffer cleared, state=D0, both status outputs cleared. Next has priority over a simultaneous digit accept. A partial ballot (D1..D3) abandoned by Next is discarded and not counted.
- Finish=1 in any state except CLOSED: state=CLOSED.
  - If state was D1..D3, the partial ballot is counted as null (Nulo+1, StatusNulo=1).
  - Finish has priority over Next and over a digit accept in the same cycle.
- CLOSED: counters, status outputs and buffer are frozen; only Reset_n leaves it.
- Counters saturate at 2^CNT_W-1 (no wrap).
- All outputs are registered; a count update is visible the cycle after the accepting edge.

Test Plan:
- Reset, Next, digits 3,4,9,4 -> C1=1, others 0, StatusValido=1, StatusNulo=0.
- Next, 3,4,8,5; Next, 3,4,9,4; Next, 3,4,7,2; Next, 3,5,0,4 -> C1=2, C2=1, C3=1, C4=1, Nulo=0.
- Next, 3,0,0,0 -> Nulo+1, StatusNulo=1, StatusValido=0.
- Next, 3,0 then Finish -> Nulo+1, state CLOSED. Further Next and digits 3,4,9,4 leave all totals unchanged.
- Next, 3,4 then Next, 3,4,9,4 -> the partial ballot is discarded and only C1+1. A 5th digit after completion is ignored.
- Assert Reset_n low mid-ballot and asynchronously to Clock -> all outputs 0 immediately. The next full ballot counts normally without needing Next first.

Source files
------------

// File: rtl/urna_module.sv
// Four-candidate ballot box: collects a 4-digit BCD code per ballot,
// tallies candidate or null votes, and freezes totals on Finish.
module urna_module #(
   parameter int unsigned CNT_W   = 8,
   parameter logic [15:0] CODE_C1 = 16'h3494,
   parameter logic [15:0] CODE_C2 = 16'h3485,
   parameter logic [15:0] CODE_C3 = 16'h3472,
   parameter logic [15:0] CODE_C4 = 16'h3504
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [3:0]       Digit,
   input  logic             Valid,
   input  logic             Next,
   input  logic             Finish,
   output logic [CNT_W-1:0] C1,
   output logic [CNT_W-1:0] C2,
   output logic [CNT_W-1:0] C3,
   output logic [CNT_W-1:0] C4,
   output logic [CNT_W-1:0] Nulo,
   output logic             StatusValido,
   output logic             StatusNulo
);

   typedef enum logic [2:0] {
      D0     = 3'd0,
      D1     = 3'd1,
      D2     = 3'd2,
      D3     = 3'd3,
      DONE   = 3'd4,
      CLOSED = 3'd5
   } state_t;

   state_t      state;
   logic        valid_q;
   logic [15:0] code_buf;
   logic        accept;
   logic [15:0] full_code;

   // Saturating increment so totals never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Digit accepted on the falling edge of the Valid strobe.
   assign accept    = valid_q & ~Valid;
   assign full_code = {code_buf[11:0], Digit};

   // Ballot FSM, digit buffer, counters and status flags.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= D0;
         valid_q      <= 1'b0;
         code_buf     <= 16'h0000;
         C1           <= '0;
         C2           <= '0;
         C3           <= '0;
         C4           <= '0;
         Nulo         <= '0;
         StatusValido <= 1'b0;
         StatusNulo   <= 1'b0;
      end else begin
         valid_q <= Valid;
         if (state != CLOSED) begin
            if (Finish) begin
               // Closing mid-ballot counts the partial code as null.
               state <= CLOSED;
               if (state == D1 || state == D2 || state == D3) begin
                  Nulo         <= sat_inc(Nulo);
                  StatusNulo   <= 1'b1;
                  StatusValido <= 1'b0;
               end
            end else if (Next) begin
               state        <= D0;
               code_buf     <= 16'h0000;
               StatusValido <= 1'b0;
               StatusNulo   <= 1'b0;
            end else if (accept) begin
               case (state)
                  D0: begin
                     code_buf <= full_code;
                     state    <= D1;
                  end
                  D1: begin
                     code_buf <= full_code;
                     state    <= D2;
                  end
                  D2: begin
                     code_buf <= full_code;
                     state    <= D3;
                  end
                  D3: begin
                     code_buf     <= full_code;
                     state        <= DONE;
                     StatusValido <= 1'b1;
                     StatusNulo   <= 1'b0;
                     if (full_code == CODE_C1)      C1 <= sat_inc(C1);
                     else if (full_code == CODE_C2) C2 <= sat_inc(C2);
                     else if (full_code == CODE_C3) C3 <= sat_inc(C3);
                     else if (full_code == CODE_C4) C4 <= sat_inc(C4);
                     else begin
                        Nulo         <= sat_inc(Nulo);
                        StatusValido <= 1'b0;
                        StatusNulo   <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_urna_module.sv
// Directed self-checking bench for urna_module.
module tb_urna_module;

   logic       Clock = 1'b0;
   logic       Reset_n;
   logic [3:0] Digit;
   logic       Valid;
   logic       Next;
   logic       Finish;
   logic [7:0] C1, C2, C3, C4, Nulo;
   logic       StatusValido, StatusNulo;

   int nvec = 0;
   int nerr = 0;

   urna_module dut (
      .Clock(Clock), .Reset_n(Reset_n), .Digit(Digit), .Valid(Valid),
      .Next(Next), .Finish(Finish), .C1(C1), .C2(C2), .C3(C3), .C4(C4),
      .Nulo(Nulo), .StatusValido(StatusValido), .StatusNulo(StatusNulo)
   );

   always #5 Clock = ~Clock;

   task automatic key_digit(input logic [3:0] d);
      @(negedge Clock);
      Digit = d;
      Valid = 1'b1;
      @(negedge Clock);
      Valid = 1'b0;
      @(negedge Clock);
   endtask

   task automatic key_code(input logic [15:0] c);
      key_digit(c[15:12]);
      key_digit(c[11:8]);
      key_digit(c[7:4]);
      key_digit(c[3:0]);
   endtask

   task automatic pulse_next();
      @(negedge Clock);
      Next = 1'b1;
      @(negedge Clock);
      Next = 1'b0;
   endtask

   task automatic pulse_finish();
      @(negedge Clock);
      Finish = 1'b1;
      @(negedge Clock);
      Finish = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge Clock);
      Reset_n = 1'b0;
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      Digit = 4'h0; Valid = 1'b0; Next = 1'b0; Finish = 1'b0;
      repeat (2) @(negedge Clock);
      nvec++;
      if ({C1, C2, C3, C4, Nulo} !== 40'h0) begin
         nerr++;
         $display("FAIL reset_counts: got %h expected %h", {C1, C2, C3, C4, Nulo}, 40'h0);
      end
      nvec++;
      if ({StatusValido, StatusNulo} !== 2'b00) begin
         nerr++;
         $display("FAIL reset_status: got %b expected 00", {StatusValido, StatusNulo});
      end
      Reset_n = 1'b1;
      @(negedge Clock);
   endtask

   task automatic test_first_vote();
      pulse_next();
      key_code(16'h3494);
      nvec++;
      if ({C1, C2, C3, C4, Nulo} !== {8'd1, 8'd0, 8'd0, 8'd0, 8'd0}) begin
         nerr++;
         $display("FAIL first_vote: got %h expected 0100000000", {C1, C2, C3, C4, Nulo});
      end
      nvec++;
      if ({StatusValido, StatusNulo} !== 2'b10) begin
         nerr++;
         $display("FAIL first_vote_status: got %b expected 10", {StatusValido, StatusNulo});
      end
   endtask

   task automatic test_all_candidates();
      pulse_next(); key_code(16'h3485);
      pulse_next(); key_code(16'h3494);
      pulse_next(); key_code(16'h3472);
      pulse_next(); key_code(16'h3504);
      nvec++;
      if ({C1, C2, C3, C4, Nulo} !== {8'd2, 8'd1, 8'd1, 8'd1, 8'd0}) begin
         nerr++;
         $display("FAIL all_candidates: got %h expected 0201010100", {C1, C2, C3, C4, Nulo});
      end
   endtask

   task automatic test_null();
      pulse_next();
      key_code(16'h3000);
      nvec++;
      if ({C1, C2, C3, C4, Nulo} !== {8'd2, 8'd1, 8'd1, 8'd1, 8'd1}) begin
         nerr++;
         $display("FAIL null_vote: got %h expected 0201010101", {C1, C2, C3, C4, Nulo});
      end
      nvec++;
      if ({StatusValido, StatusNulo} !== 2'b01) begin
         nerr++;
         $display("FAIL null_status: got %b expected 01", {StatusValido, StatusNulo});
      end
   endtask

   // Next coinciding with the 4th digit accept wins; ballot is discarded.
   task automatic test_next_priority();
      pulse_next();
      key_digit(4'h3); key_digit(4'h4); key_digit(4'h9);
      @(negedge Clock);
      Digit = 4'h4; Valid = 1'b1;
      @(negedge Clock);
      Valid = 1'b0; Next = 1'b1;
      @(negedge Clock);
      Next = 1'b0;
      nvec++;
      if ({C1, Nulo, StatusValido, StatusNulo} !== {8'd2, 8'd1, 2'b00}) begin
         nerr++;
         $display("FAIL next_priority: got C1=%0d Nulo=%0d st=%b expected C1=2 Nulo=1 st=00",
                  C1, Nulo, {StatusValido, StatusNulo});
      end
      key_code(16'h3494);
      nvec++;
      if (C1 !== 8'd3) begin
         nerr++;
         $display("FAIL after_next_priority: got C1=%0d expected 3", C1);
      end
   endtask

   task automatic test_finish_partial();
      pulse_next();
      key_digit(4'h3); key_digit(4'h0);
      pulse_finish();
      nvec++;
      if ({C1, C2, C3, C4, Nulo} !== {8'd3, 8'd1, 8'd1, 8'd1, 8'd2}) begin
         nerr++;
         $display("FAIL finish_partial: got %h expected 0301010102", {C1, C2, C3, C4, Nulo});
      end
      nvec++;
      if ({StatusValido, StatusNulo} !== 2'b01) begin
         nerr++;
         $display("FAIL finish_status: got %b expected 01", {StatusValido, StatusNulo});
      end
      pulse_next();
      key_code(16'h3494);
      nvec++;
      if ({C1, C2, C3, C4, Nulo, StatusValido, StatusNulo} !==
          {8'd3, 8'd1, 8'd1, 8'd1, 8'd2, 2'b01}) begin
         nerr++;
         $display("FAIL closed_frozen: got %h st=%b expected 0301010102 st=01",
                  {C1, C2, C3, C4, Nulo}, {StatusValido, StatusNulo});
      end
   endtask

   task automatic test_abandon();
      pulse_reset();
      nvec++;
      if ({C1, C2, C3, C4, Nulo} !== 40'h0) begin
         nerr++;
         $display("FAIL reset_after_close: got %h expected 0", {C1, C2, C3, C4, Nulo});
      end
      pulse_next();
      key_digit(4'h3); key_digit(4'h4);
      pulse_next();
      key_code(16'h3494);
      nvec++;
      if ({C1, C2, C3, C4, Nulo} !== {8'd1, 8'd0, 8'd0, 8'd0, 8'd0}) begin
         nerr++;
         $display("FAIL abandon_partial: got %h expected 0100000000", {C1, C2, C3, C4, Nulo});
      end
      key_digit(4'h4);
      nvec++;
      if ({C1, C2, C3, C4, Nulo, StatusValido, StatusNulo} !==
          {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 2'b10}) begin
         nerr++;
         $display("FAIL fifth_digit: got %h st=%b expected 0100000000 st=10",
                  {C1, C2, C3, C4, Nulo}, {StatusValido, StatusNulo});
      end
   endtask

   task automatic test_async_reset();
      pulse_next();
      key_digit(4'h3); key_digit(4'h4);
      @(posedge Clock);
      #3 Reset_n = 1'b0;
      #1;
      nvec++;
      if ({C1, C2, C3, C4, Nulo, StatusValido, StatusNulo} !== 42'h0) begin
         nerr++;
         $display("FAIL async_reset: got %h st=%b expected all 0",
                  {C1, C2, C3, C4, Nulo}, {StatusValido, StatusNulo});
      end
      @(negedge Clock);
      Reset_n = 1'b1;
      key_code(16'h3494);
      nvec++;
      if ({C1, C2, C3, C4, Nulo, StatusValido} !== {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1}) begin
         nerr++;
         $display("FAIL vote_after_reset: got %h sv=%b expected 0100000000 sv=1",
                  {C1, C2, C3, C4, Nulo}, StatusValido);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 255; i++) begin
         pulse_next();
         key_code(16'hFFFF);
      end
      nvec++;
      if (Nulo !== 8'd255) begin
         nerr++;
         $display("FAIL sat_reach: got Nulo=%0d expected 255", Nulo);
      end
      pulse_next();
      key_code(16'hFFFF);
      nvec++;
      if ({Nulo, C1, StatusNulo} !== {8'd255, 8'd1, 1'b1}) begin
         nerr++;
         $display("FAIL sat_hold: got Nulo=%0d C1=%0d sn=%b expected 255 1 1",
                  Nulo, C1, StatusNulo);
      end
   endtask

   initial begin
      test_reset();
      test_first_vote();
      test_all_candidates();
      test_null();
      test_next_priority();
      test_finish_partial();
      test_abandon();
      test_async_reset();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
